// File: rtl/fft_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_ctrl_if
// Description : Sample-in and result-out stream bundle for fft_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_frame_ctrl_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_real;
    logic [31:0] out_img;
    logic [2:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    // Environment side: sample source and result consumer
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_real, out_img, out_idx, out_valid, out_last
    );

    // Controller side
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_real, out_img, out_idx, out_valid, out_last
    );
endinterface
`default_nettype wire

// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_ctrl
// Description : Gathers 8 samples into the FFT inputs, then sweeps the bin
//               select and streams each bin's real/imag result out.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_ctrl #(
    parameter int MUX_LAT    = 1,
    parameter int SETTLE_CYC = 1
) (
    input  wire              clk,
    input  wire              rst,
    fft_frame_ctrl_if.slave  bus,
    output logic [31:0]      fft_x0,
    output logic [31:0]      fft_x1,
    output logic [31:0]      fft_x2,
    output logic [31:0]      fft_x3,
    output logic [31:0]      fft_x4,
    output logic [31:0]      fft_x5,
    output logic [31:0]      fft_x6,
    output logic [31:0]      fft_x7,
    output logic [2:0]       fft_sel,
    input  wire  [31:0]      fft_real,
    input  wire  [31:0]      fft_img,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        S_FILL    = 3'd0,
        S_SETTLE  = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_PRESENT = 3'd4
    } state_t;

    localparam logic [7:0] c_SETTLE_END = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] c_WAIT_END   = 8'(MUX_LAT - 1);

    state_t      r_state;
    logic [2:0]  r_wr_cnt;
    logic [2:0]  r_rd_idx;
    logic [2:0]  r_sel;
    logic [7:0]  r_cnt;
    logic [31:0] r_x [8];
    logic [31:0] r_out_real;
    logic [31:0] r_out_img;
    logic [2:0]  r_out_idx;
    logic        r_out_valid;
    logic        r_out_last;
    logic        r_frame_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_FILL;
            r_wr_cnt     <= 3'd0;
            r_rd_idx     <= 3'd0;
            r_sel        <= 3'd0;
            r_cnt        <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                r_x[i] <= 32'd0;
            end
            r_out_real   <= 32'd0;
            r_out_img    <= 32'd0;
            r_out_idx    <= 3'd0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (bus.in_valid) begin
                        r_x[r_wr_cnt] <= bus.in_data;
                        r_wr_cnt      <= r_wr_cnt + 3'd1;
                        if (r_wr_cnt == 3'd7) begin
                            r_rd_idx <= 3'd0;
                            r_sel    <= 3'd0;
                            r_cnt    <= 8'd0;
                            r_state  <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == c_SETTLE_END) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                // Select is already stable here; only wait out the FFT mux latency
                S_WAIT: begin
                    if (r_cnt == c_WAIT_END) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_CAPTURE: begin
                    r_out_real  <= fft_real;
                    r_out_img   <= fft_img;
                    r_out_idx   <= r_rd_idx;
                    r_out_valid <= 1'b1;
                    r_out_last  <= (r_rd_idx == 3'd7);
                    r_state     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_rd_idx == 3'd7) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_FILL;
                        end else begin
                            r_rd_idx <= r_rd_idx + 3'd1;
                            r_sel    <= r_rd_idx + 3'd1;
                            r_state  <= S_WAIT;
                        end
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_FILL);
    assign bus.out_real  = r_out_real;
    assign bus.out_img   = r_out_img;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;

    assign fft_x0     = r_x[0];
    assign fft_x1     = r_x[1];
    assign fft_x2     = r_x[2];
    assign fft_x3     = r_x[3];
    assign fft_x4     = r_x[4];
    assign fft_x5     = r_x[5];
    assign fft_x6     = r_x[6];
    assign fft_x7     = r_x[7];
    assign fft_sel    = r_sel;
    assign busy       = (r_state != S_FILL);
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
